// File: rtl/frame_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_align_pkg
// Description : Shared types for the frame alignment controller: lane state
//               encoding, counter widths and a saturating slip increment.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_align_pkg;

    // Counter widths shared by every lane
    localparam int c_slip_w   = 8;
    localparam int c_settle_w = 8;
    localparam int c_match_w  = 4;
    localparam int c_loss_w   = 4;

    // Per-lane alignment state
    typedef enum logic [1:0] {
        ST_CHECK  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } lane_state_t;

    typedef logic [c_slip_w-1:0]   slip_cnt_t;
    typedef logic [c_settle_w-1:0] settle_cnt_t;
    typedef logic [c_match_w-1:0]  match_cnt_t;
    typedef logic [c_loss_w-1:0]   loss_cnt_t;

    // All per-lane counters bundled so they can be cleared in one assignment
    typedef struct packed {
        slip_cnt_t   slip;
        settle_cnt_t settle;
        match_cnt_t  match;
        loss_cnt_t   loss;
    } lane_cnt_t;

    // Slip counter increment that holds at all-ones instead of wrapping
    function automatic slip_cnt_t sat_inc_slip(input slip_cnt_t v);
        return (v == '1) ? v : v + slip_cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_align_lane.sv
`default_nettype none
// ============================================================================
// Module      : frame_align_lane
// Description : Single-lane word alignment. Registers the deserialised word,
//               compares it with the framing pattern and issues bitslip
//               pulses until the pattern is seen LOCK_CNT times in a row.
//               Tracks loss of lock and gives up after MAX_SLIP slips.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_align_lane
    import frame_align_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] PATTERN    = 8'hF0,
    parameter int                SETTLE_CYC = 16,
    parameter int                LOCK_CNT   = 4,
    parameter int                LOSS_CNT   = 4,
    parameter int                MAX_SLIP   = 8
) (
    input  logic              clk_div,
    input  logic              rst_in,
    input  logic              restart,
    input  logic [DATA_W-1:0] frame_in,
    output logic              bitslip,
    output logic              locked,
    output logic              fail,
    output logic [7:0]        slip_cnt
);

    localparam settle_cnt_t c_settle_last = settle_cnt_t'(SETTLE_CYC - 1);
    localparam match_cnt_t  c_lock_cnt    = match_cnt_t'(LOCK_CNT);
    localparam loss_cnt_t   c_loss_cnt    = loss_cnt_t'(LOSS_CNT);
    localparam slip_cnt_t   c_max_slip    = slip_cnt_t'(MAX_SLIP);

    logic [DATA_W-1:0] r_data_q;
    logic              r_data_vld;
    lane_state_t       r_state;
    lane_cnt_t         r_cnt;
    logic              r_bitslip;
    logic              r_locked;
    logic              r_fail;

    lane_state_t       w_state_nxt;
    lane_cnt_t         w_cnt_nxt;
    logic              w_bitslip_nxt;
    logic              w_match;
    match_cnt_t        w_match_inc;
    loss_cnt_t         w_loss_inc;

    assign w_match     = (r_data_q == PATTERN);
    assign w_match_inc = r_cnt.match + match_cnt_t'(1);
    assign w_loss_inc  = r_cnt.loss + loss_cnt_t'(1);

    // Input word register; the valid flag keeps the post-reset zero word
    // from being judged as a mismatch
    always_ff @(posedge clk_div or posedge rst_in) begin
        if (rst_in) begin
            r_data_q   <= '0;
            r_data_vld <= 1'b0;
        end else begin
            r_data_q   <= frame_in;
            r_data_vld <= 1'b1;
        end
    end

    // Lane state and counter register
    always_ff @(posedge clk_div or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_CHECK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; restart overrides every transition
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bitslip_nxt = 1'b0;

        case (r_state)
            ST_CHECK: begin
                if (r_data_vld) begin
                    if (w_match) begin
                        w_cnt_nxt.match = w_match_inc;
                        if (w_match_inc == c_lock_cnt) begin
                            w_state_nxt     = ST_LOCKED;
                            w_cnt_nxt.match = '0;
                            w_cnt_nxt.loss  = '0;
                        end
                    end else if (r_cnt.slip < c_max_slip) begin
                        // Misaligned: request one slip and blank the input
                        w_state_nxt      = ST_WAIT;
                        w_bitslip_nxt    = 1'b1;
                        w_cnt_nxt.slip   = sat_inc_slip(r_cnt.slip);
                        w_cnt_nxt.match  = '0;
                        w_cnt_nxt.settle = '0;
                    end else begin
                        // Slip budget exhausted without finding the pattern
                        w_state_nxt     = ST_FAIL;
                        w_cnt_nxt.match = '0;
                    end
                end
            end

            ST_WAIT: begin
                // Deserialiser output is unreliable right after a slip
                if (r_cnt.settle == c_settle_last) begin
                    w_state_nxt      = ST_CHECK;
                    w_cnt_nxt.settle = '0;
                    w_cnt_nxt.match  = '0;
                end else begin
                    w_cnt_nxt.settle = r_cnt.settle + settle_cnt_t'(1);
                end
            end

            ST_LOCKED: begin
                if (w_match) begin
                    w_cnt_nxt.loss = '0;
                end else if (w_loss_inc == c_loss_cnt) begin
                    // Lock lost: start alignment from scratch
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt.loss = w_loss_inc;
                end
            end

            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end

            default: begin
                w_state_nxt = ST_CHECK;
                w_cnt_nxt   = '0;
            end
        endcase

        if (restart) begin
            w_state_nxt   = ST_CHECK;
            w_cnt_nxt     = '0;
            w_bitslip_nxt = 1'b0;
        end
    end

    // Registered status outputs; lock and fail follow the state one cycle late
    always_ff @(posedge clk_div or posedge rst_in) begin
        if (rst_in) begin
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
        end else if (restart) begin
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_bitslip <= w_bitslip_nxt;
            r_locked  <= (r_state == ST_LOCKED);
            r_fail    <= (r_state == ST_FAIL);
        end
    end

    assign bitslip  = r_bitslip;
    assign locked   = r_locked;
    assign fail     = r_fail;
    assign slip_cnt = r_cnt.slip;

endmodule
`default_nettype wire

// File: rtl/frame_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_align_ctrl
// Description : Multi-lane frame alignment controller. One independent
//               alignment lane per channel plus a registered all-lanes-locked
//               summary flag.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_align_ctrl
    import frame_align_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] PATTERN    = 8'hF0,
    parameter int                SETTLE_CYC = 16,
    parameter int                LOCK_CNT   = 4,
    parameter int                LOSS_CNT   = 4,
    parameter int                MAX_SLIP   = 8
) (
    input  logic                     clk_div,
    input  logic                     rst_in,
    input  logic [NUM_CH*DATA_W-1:0] frame_in,
    input  logic                     restart,
    output logic [NUM_CH-1:0]        bitslip,
    output logic [NUM_CH-1:0]        locked,
    output logic [NUM_CH-1:0]        fail,
    output logic                     all_locked,
    output logic [NUM_CH*8-1:0]      slip_cnt
);

    logic r_all_locked;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
            frame_align_lane #(
                .DATA_W     (DATA_W),
                .PATTERN    (PATTERN),
                .SETTLE_CYC (SETTLE_CYC),
                .LOCK_CNT   (LOCK_CNT),
                .LOSS_CNT   (LOSS_CNT),
                .MAX_SLIP   (MAX_SLIP)
            ) u_lane (
                .clk_div  (clk_div),
                .rst_in   (rst_in),
                .restart  (restart),
                .frame_in (frame_in[g*DATA_W +: DATA_W]),
                .bitslip  (bitslip[g]),
                .locked   (locked[g]),
                .fail     (fail[g]),
                .slip_cnt (slip_cnt[g*c_slip_w +: c_slip_w])
            );
        end
    endgenerate

    // Summary flag reflects the lane lock bits of the previous cycle
    always_ff @(posedge clk_div or posedge rst_in) begin
        if (rst_in) begin
            r_all_locked <= 1'b0;
        end else if (restart) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &locked;
        end
    end

    assign all_locked = r_all_locked;

endmodule
`default_nettype wire

// File: tb/tb_frame_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_align_ctrl
// Description : Scoreboard bench for frame_align_ctrl. Stimulus pushes the
//               expected output events (bitslip pulses, lock/fail edges,
//               all_locked edges) with their cycle and slip count; a monitor
//               on the falling edge pops and compares each observed event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_align_ctrl;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 8;
    localparam int SETTLE_CYC = 16;
    localparam int LOCK_CNT   = 4;
    localparam int LOSS_CNT   = 4;
    localparam int MAX_SLIP   = 8;
    localparam int P          = SETTLE_CYC + 1;   // bitslip pulse spacing

    localparam int EV_SLIP  = 1;
    localparam int EV_LRISE = 2;
    localparam int EV_LFALL = 3;
    localparam int EV_FRISE = 4;
    localparam int EV_FFALL = 5;
    localparam int EV_ARISE = 6;
    localparam int EV_AFALL = 7;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  slip;
    } ev_t;

    logic                     clk_div;
    logic                     rst_in;
    logic                     restart;
    logic [NUM_CH*DATA_W-1:0] frame_in;
    logic [NUM_CH-1:0]        bitslip;
    logic [NUM_CH-1:0]        locked;
    logic [NUM_CH-1:0]        fail;
    logic                     all_locked;
    logic [NUM_CH*8-1:0]      slip_cnt;

    logic [7:0] w0, w1, w2, w3;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    ev_t        exp_q [0:NUM_CH][$];
    logic [NUM_CH-1:0] prev_bs = '0;
    logic [NUM_CH-1:0] prev_lk = '0;
    logic [NUM_CH-1:0] prev_fl = '0;
    logic              prev_al = 1'b0;
    int         rel, r, s, t, u, rel2;
    logic       found;

    assign frame_in = {w3, w2, w1, w0};

    frame_align_ctrl #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .PATTERN    (8'hF0),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT),
        .LOSS_CNT   (LOSS_CNT),
        .MAX_SLIP   (MAX_SLIP)
    ) dut (
        .clk_div    (clk_div),
        .rst_in     (rst_in),
        .frame_in   (frame_in),
        .restart    (restart),
        .bitslip    (bitslip),
        .locked     (locked),
        .fail       (fail),
        .all_locked (all_locked),
        .slip_cnt   (slip_cnt)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    always @(posedge clk_div) cyc <= cyc + 1;

    // Lane 1 deserialiser model: starts three slips away from F0 and rotates
    // one bit for every bitslip pulse it receives
    always @(posedge clk_div or posedge rst_in) begin
        if (rst_in)
            w1 <= 8'h1E;
        else if (restart)
            w1 <= 8'h1E;
        else if (bitslip[1])
            w1 <= {w1[6:0], w1[7]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int q, input int kind, input int c, input int slip);
        ev_t e;
        e.kind = 4'(kind);
        e.cyc  = 32'(c);
        e.slip = 8'(slip);
        exp_q[q].push_back(e);
    endtask

    task automatic got_event(input int q, input int kind, input logic [7:0] slip);
        ev_t e;
        if (exp_q[q].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected event q%0d: got kind %0d at cycle %0d, required none", q, kind, cyc);
        end else begin
            e = exp_q[q].pop_front();
            chk($sformatf("q%0d event kind", q), 32'(kind), 32'(e.kind));
            chk($sformatf("q%0d kind %0d cycle", q, kind), 32'(cyc), e.cyc);
            chk($sformatf("q%0d kind %0d slip_cnt", q, kind), 32'(slip), 32'(e.slip));
        end
    endtask

    task automatic drain(input string ph);
        for (int q = 0; q <= NUM_CH; q++)
            chk($sformatf("%s q%0d pending events", ph, q), 32'(exp_q[q].size()), 0);
    endtask

    task automatic chk_all_zero(input string ph);
        chk({ph, " bitslip"},    32'(bitslip),    0);
        chk({ph, " locked"},     32'(locked),     0);
        chk({ph, " fail"},       32'(fail),       0);
        chk({ph, " all_locked"}, 32'(all_locked), 0);
        chk({ph, " slip_cnt"},   slip_cnt,        0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    // Post-release expectations shared by the power-on and mid-run resets
    task automatic push_release(input int base, input int lane2_pulses, input logic lane2_fails);
        push(0, EV_LRISE, base + LOCK_CNT + 2, 0);
        push(3, EV_LRISE, base + LOCK_CNT + 2, 0);
        for (int k = 0; k < 3; k++)
            push(1, EV_SLIP, base + 2 + k*P, k + 1);
        push(1, EV_LRISE, base + 2 + 2*P + SETTLE_CYC + LOCK_CNT + 1, 3);
        for (int k = 0; k < lane2_pulses; k++)
            push(2, EV_SLIP, base + 2 + k*P, k + 1);
        if (lane2_fails)
            push(2, EV_FRISE, base + 2 + (MAX_SLIP-1)*P + SETTLE_CYC + 2, MAX_SLIP);
    endtask

    // Monitor: turns output edges into events and checks them in order
    always @(negedge clk_div) begin
        if (!rst_in) begin
            for (int l = 0; l < NUM_CH; l++) begin
                if (bitslip[l]) begin
                    chk($sformatf("lane%0d bitslip isolation", l),
                        {29'd0, prev_bs[l], locked[l], fail[l]}, 0);
                    got_event(l, EV_SLIP, slip_cnt[l*8 +: 8]);
                end
                if (locked[l] && !prev_lk[l]) got_event(l, EV_LRISE, slip_cnt[l*8 +: 8]);
                if (!locked[l] && prev_lk[l]) got_event(l, EV_LFALL, slip_cnt[l*8 +: 8]);
                if (fail[l] && !prev_fl[l])   got_event(l, EV_FRISE, slip_cnt[l*8 +: 8]);
                if (!fail[l] && prev_fl[l])   got_event(l, EV_FFALL, slip_cnt[l*8 +: 8]);
            end
            if (all_locked && !prev_al) got_event(NUM_CH, EV_ARISE, 8'd0);
            if (!all_locked && prev_al) got_event(NUM_CH, EV_AFALL, 8'd0);
        end
        prev_bs = bitslip;
        prev_lk = locked;
        prev_fl = fail;
        prev_al = all_locked;
    end

    initial begin
        rst_in  = 1'b1;
        restart = 1'b0;
        w0      = 8'hF0;
        w2      = 8'h00;
        w3      = 8'hF0;
        found   = 1'b0;

        // Phase A: power-on alignment
        tick(3);
        chk_all_zero("reset");
        rst_in = 1'b0;
        rel    = cyc;
        push_release(rel, MAX_SLIP, 1'b1);
        tick(150);
        chk("A lane2 fail", 32'(fail[2]), 1);
        chk("A lane2 slip_cnt", 32'(slip_cnt[23:16]), MAX_SLIP);
        drain("A");

        // Phase B: restart clears everything and alignment resumes
        r = cyc + 1;
        push(0, EV_LFALL, r, 0);
        push(1, EV_LFALL, r, 0);
        push(3, EV_LFALL, r, 0);
        push(2, EV_FFALL, r, 0);
        push(2, EV_SLIP, r + 1, 1);
        push(2, EV_LRISE, r + 2 + SETTLE_CYC + LOCK_CNT, 1);
        push(0, EV_LRISE, r + LOCK_CNT + 1, 0);
        push(3, EV_LRISE, r + LOCK_CNT + 1, 0);
        for (int k = 0; k < 3; k++)
            push(1, EV_SLIP, r + 2 + k*P, k + 1);
        push(1, EV_LRISE, r + 2 + 2*P + SETTLE_CYC + LOCK_CNT + 1, 3);
        push(NUM_CH, EV_ARISE, r + 2 + 2*P + SETTLE_CYC + LOCK_CNT + 2, 0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk_all_zero("restart");
        tick(2);
        w2 = 8'hF0;
        tick(68);
        drain("B");

        // Phase C: short error burst keeps lock, longer one drops it
        s  = cyc;
        w0 = 8'hAA;
        tick(3);
        w0 = 8'hF0;
        tick(6);
        t = cyc;
        push(0, EV_SLIP,  t + 2 + LOSS_CNT, 1);
        push(0, EV_LFALL, t + 2 + LOSS_CNT, 1);
        push(0, EV_LRISE, t + 2 + LOSS_CNT + SETTLE_CYC + LOCK_CNT + 1, 1);
        push(NUM_CH, EV_AFALL, t + 3 + LOSS_CNT, 0);
        push(NUM_CH, EV_ARISE, t + 3 + LOSS_CNT + SETTLE_CYC + LOCK_CNT + 1, 0);
        w0 = 8'hAA;
        tick(5);
        w0 = 8'hF0;
        tick(35);
        chk("C burst start sanity", 32'(t - s), 9);
        drain("C");

        // Phase D: asynchronous reset while lane 2 has bitslip high
        u = cyc;
        push(2, EV_SLIP,  u + 2 + LOSS_CNT, 1);
        push(2, EV_LFALL, u + 2 + LOSS_CNT, 1);
        w2 = 8'h00;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_div);
            if (bitslip[2]) found = 1'b1;
        end
        chk("D lane2 bitslip seen before timeout", 32'(found), 1);
        #2;
        rst_in = 1'b1;
        #1;
        chk_all_zero("async reset");
        tick(2);
        rst_in = 1'b0;
        rel2   = cyc;
        push_release(rel2, 4, 1'b0);
        tick(60);
        drain("D");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_align_ctrl.md
FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent frame lanes.
REQ-002 Parameter DATA_W, default 8: deserialised frame word width per lane.
REQ-003 Parameter PATTERN, default 8'hF0 (DATA_W bits): expected frame word.
REQ-004 Parameter SETTLE_CYC, default 16, range 1..255: blanking cycles after each bitslip pulse.
REQ-005 Parameter LOCK_CNT, default 4, range 1..15: consecutive matches required to declare lock.
REQ-006 Parameter LOSS_CNT, default 4, range 1..15: consecutive mismatches while locked that drop lock.
REQ-007 Parameter MAX_SLIP, default 8, range 1..255: bitslip attempts before a lane fails.
REQ-008 clk_div  in  1  divided parallel-word clock; the only clock.
REQ-009 rst_in  in  1  asynchronous active-high reset.
REQ-010 frame_in  in  NUM_CH*DATA_W  deserialiser words; lane i is bits [i*DATA_W +: DATA_W].
REQ-011 restart  in  1  synchronous pulse restarting alignment on all lanes.
REQ-012 bitslip  out  NUM_CH  one-cycle bitslip request per lane, registered.
REQ-013 locked  out  NUM_CH  per-lane lock flag, registered.
REQ-014 fail  out  NUM_CH  per-lane alignment-failure flag, registered.
REQ-015 all_locked  out  1  AND of locked, registered.
REQ-016 slip_cnt  out  NUM_CH*8  per-lane bitslips issued since last (re)start, saturating at 255.

Function
REQ-017 Each lane shall register its frame_in word once before comparison (data_q); comparison is full-width equality with PATTERN.
REQ-018 Each lane shall run an FSM with states CHECK, WAIT, LOCKED, FAIL; the state after reset and after restart is CHECK.
REQ-019 CHECK, data_q==PATTERN: match counter increments; when it reaches LOCK_CNT the lane enters LOCKED and locked rises next cycle.
REQ-020 CHECK, data_q!=PATTERN and slip_cnt<MAX_SLIP: bitslip pulses high for exactly one cycle, slip_cnt increments, match counter clears, lane enters WAIT.
REQ-021 CHECK, data_q!=PATTERN and slip_cnt==MAX_SLIP: no bitslip; lane enters FAIL, fail rises next cycle.
REQ-022 Latency from a mismatching frame_in word to bitslip high: 2 clk_div cycles.
REQ-023 WAIT: data_q is ignored for SETTLE_CYC cycles, then the lane returns to CHECK with match counter 0.
REQ-024 LOCKED: mismatch increments loss counter, match clears it; on reaching LOSS_CNT the lane returns to CHECK, locked falls, slip_cnt and counters clear.
REQ-025 FAIL: terminal; fail held high, bitslip low, until restart or rst_in.
REQ-026 restart shall take priority over all FSM transitions: on the cycle after restart high, every lane is in CHECK with locked, fail, bitslip and all counters at 0.
REQ-027 bitslip shall never be high on two consecutive cycles on any lane, and never while locked or fail is high.
REQ-028 Lanes shall be fully independent; a lane's fail or loss of lock shall not affect other lanes except through all_locked.
REQ-029 all_locked shall be high only when all NUM_CH locked bits were high the previous cycle.

Reset
REQ-030 rst_in high shall asynchronously force bitslip=0, locked=0, fail=0, all_locked=0, slip_cnt=0, all internal counters 0, state CHECK.
REQ-031 Reset deassertion is synchronised externally to clk_div; the block requires no reset synchroniser.

Structure
REQ-032 Lane state enum and counter widths (8-bit slip/settle, 4-bit match/loss) shall reside in shared package frame_align_pkg.
REQ-033 Per-lane logic shall be sub-module frame_align_lane, instantiated NUM_CH times via generate; the top holds only all_locked and port packing.

Verification
REQ-034 Defaults; lane 0 feeds constant F0 -> no bitslip, locked=1 at cycle 6 after reset release (1 input reg + 4 matches + 1 output reg).
REQ-035 Lane 1 model rotates word by one bit per bitslip, starting 3 slips from F0 -> exactly 3 bitslip pulses spaced >=SETTLE_CYC+1 cycles, slip_cnt=3, then locked.
REQ-036 Lane 2 feeds constant 8'h00 -> 8 bitslip pulses, then fail=1, bitslip stays 0; restart -> fail=0, slip_cnt=0, pulses resume.
REQ-037 Locked lane receives 3 mismatches then F0 -> stays locked; 4 consecutive mismatches -> locked falls, all_locked falls, realignment begins.
REQ-038 rst_in asserted mid-WAIT with bitslip high -> all outputs 0 immediately without a clock edge; after release alignment restarts from CHECK.
